// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with a valid/ready handshake on both sides.
// Arithmetic, logic and compare ops finish in one cycle. Shifts by a nonzero
// amount run through a small two-state FSM that moves the working value by
// at most SHIFT_STEP bit positions per cycle.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   ce        clock enable; low freezes every register and blocks transfers
//   in_valid  request valid (producer holds the request until accepted)
//   in_ready  request can be accepted this cycle
//   op_sel    operation select (instr::alu_op_t)
//   operand1  first source operand
//   operand2  second source operand / shift amount in the low log2(XLEN) bits
//   out_valid result and flags are valid
//   out_ready consumer takes the result this cycle
//   result    registered result
//   flags     registered zero/sign/carry/overflow (instr::alu_flags_t)

`timescale 1ns/1ps

package instr;
  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    XOR  = 4'd2,
    OR   = 4'd3,
    AND  = 4'd4,
    LSL  = 4'd5,
    LSR  = 4'd6,
    SRA  = 4'd7,
    SLT  = 4'd8,
    SLTU = 4'd9
  } alu_op_t;

  typedef struct packed {
    logic zero;
    logic sign;
    logic carry;
    logic overflow;
  } alu_flags_t;
endpackage

module alu_pipe
  import instr::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned SHIFT_STEP = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ce,
  input  logic            in_valid,
  output logic            in_ready,
  input  alu_op_t         op_sel,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output alu_flags_t      flags
);

  localparam int unsigned SHW = $clog2(XLEN);
  localparam logic [SHW:0] STEP_W = (SHW+1)'(SHIFT_STEP);

  // Legacy encodings kept so the state register stays bit-compatible.
  localparam logic [0:0] ST_IDLE_ENC  = 1'b0;
  localparam logic [0:0] ST_SHIFT_ENC = 1'b1;

  typedef enum logic [0:0] {
    IDLE  = ST_IDLE_ENC,
    SHIFT = ST_SHIFT_ENC
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   work_q,  work_d;
  logic [SHW-1:0]    rem_q,   rem_d;
  alu_op_t           sop_q,   sop_d;
  logic              ov_q,    ov_d;
  logic [XLEN-1:0]   res_q,   res_d;
  alu_flags_t        flg_q,   flg_d;

  logic              out_free;
  logic              accept;
  logic              is_shift;
  logic [SHW-1:0]    amt;

  logic [XLEN:0]     sum;
  logic [XLEN-1:0]   diff;
  logic [XLEN-1:0]   sc_res;
  alu_flags_t        sc_flg;

  logic [SHW:0]      rem_ext;
  logic [SHW:0]      step;
  logic [SHW-1:0]    rem_left;
  logic signed [XLEN-1:0] work_s;
  logic [XLEN-1:0]   shifted;

  // Handshake: the output register is free when empty or being drained now.
  always_comb begin
    out_free = !ov_q || out_ready;
    in_ready = ce && (state_q == IDLE) && out_free;
    accept   = in_valid && in_ready;
    amt      = operand2[SHW-1:0];
    is_shift = (op_sel == LSL) || (op_sel == LSR) || (op_sel == SRA);
  end

  // Single-cycle datapath. A shift only lands here when its amount is zero,
  // in which case the result is operand1 unchanged.
  always_comb begin
    sum             = {1'b0, operand1} + {1'b0, operand2};
    diff            = operand1 - operand2;
    sc_res          = '0;
    sc_flg          = '0;
    case (op_sel)
      ADD: begin
        sc_res          = sum[XLEN-1:0];
        sc_flg.carry    = sum[XLEN];
        sc_flg.overflow = (operand1[XLEN-1] == operand2[XLEN-1]) &&
                          (sum[XLEN-1] != operand1[XLEN-1]);
      end
      SUB: begin
        sc_res          = diff;
        sc_flg.carry    = operand1 < operand2;
        sc_flg.overflow = (operand1[XLEN-1] != operand2[XLEN-1]) &&
                          (diff[XLEN-1] != operand1[XLEN-1]);
      end
      XOR:  sc_res = operand1 ^ operand2;
      OR:   sc_res = operand1 | operand2;
      AND:  sc_res = operand1 & operand2;
      SLT:  sc_res = {{(XLEN-1){1'b0}}, ($signed(operand1) < $signed(operand2))};
      SLTU: sc_res = {{(XLEN-1){1'b0}}, (operand1 < operand2)};
      LSL, LSR, SRA: sc_res = operand1;
      default: sc_res = '0;
    endcase
    sc_flg.zero = (sc_res == '0);
    sc_flg.sign = sc_res[XLEN-1];
  end

  // One shift step: min(SHIFT_STEP, remaining) positions.
  always_comb begin
    rem_ext  = {1'b0, rem_q};
    step     = (rem_ext < STEP_W) ? rem_ext : STEP_W;
    rem_left = rem_q - step[SHW-1:0];
    work_s   = work_q;
    case (sop_q)
      LSL:     shifted = work_q << step;
      LSR:     shifted = work_q >> step;
      default: shifted = work_s >>> step;
    endcase
  end

  // Next-state logic. The final shift step and the load into the output
  // register happen in the same cycle when the output is free; otherwise the
  // finished value waits in work_q with rem_q == 0 until it can be loaded.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    rem_d   = rem_q;
    sop_d   = sop_q;
    ov_d    = ov_q;
    res_d   = res_q;
    flg_d   = flg_q;

    if (ce) begin
      if (ov_q && out_ready) begin
        ov_d = 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (accept) begin
            if (is_shift && (amt != '0)) begin
              state_d = SHIFT;
              work_d  = operand1;
              rem_d   = amt;
              sop_d   = op_sel;
            end else begin
              res_d = sc_res;
              flg_d = sc_flg;
              ov_d  = 1'b1;
            end
          end
        end

        SHIFT: begin
          if (rem_q != '0) begin
            if ((rem_left == '0) && out_free) begin
              res_d          = shifted;
              flg_d          = '0;
              flg_d.zero     = (shifted == '0);
              flg_d.sign     = shifted[XLEN-1];
              ov_d           = 1'b1;
              state_d        = IDLE;
            end
            work_d = shifted;
            rem_d  = rem_left;
          end else if (out_free) begin
            res_d      = work_q;
            flg_d      = '0;
            flg_d.zero = (work_q == '0);
            flg_d.sign = work_q[XLEN-1];
            ov_d       = 1'b1;
            state_d    = IDLE;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      rem_q   <= '0;
      sop_q   <= LSL;
      ov_q    <= 1'b0;
      res_q   <= '0;
      flg_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      sop_q   <= sop_d;
      ov_q    <= ov_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
    end
  end

  assign out_valid = ov_q;
  assign result    = res_q;
  assign flags     = flg_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed testbench for alu_pipe (XLEN=32, SHIFT_STEP=8). Stimulus pushes
// expected results into a scoreboard; a monitor pops and compares on each
// output transfer. Timing/observation checks go through a probe queue that
// the same monitor evaluates.

`timescale 1ns/1ps

module tb_alu_pipe;
  import instr::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce;
  logic        in_valid;
  logic        in_ready;
  alu_op_t     op_sel;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  alu_flags_t  flags;

  alu_pipe #(.XLEN(32), .SHIFT_STEP(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ce        (ce),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sel    (op_sel),
    .operand1  (operand1),
    .operand2  (operand2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
    bit          chain;
    string       name;
  } exp_t;

  typedef struct {
    string       name;
    logic [63:0] act;
    logic [63:0] exp;
  } prb_t;

  exp_t sbq[$];
  prb_t prq[$];
  int   passed = 0;
  int   total  = 0;
  int   cyc    = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: scoreboard compare on output transfers, then drain probes.
  initial begin : monitor
    exp_t        e;
    prb_t        p;
    int          last_xfer;
    logic [3:0]  fl;
    last_xfer = -10;
    forever begin
      @(negedge clk);
      if (rst_n && ce && out_valid && out_ready) begin
        fl = flags;
        if (sbq.size() == 0) begin
          total++;
          $display("FAIL unexpected_output: result=%h flags=%b, expected no output", result, fl);
        end else begin
          e = sbq.pop_front();
          total++;
          if (result === e.res) passed++;
          else $display("FAIL %s.result: got %h expected %h", e.name, result, e.res);
          total++;
          if (fl === e.flg) passed++;
          else $display("FAIL %s.flags: got %b expected %b (zscv)", e.name, fl, e.flg);
          if (e.chain) begin
            total++;
            if (cyc == last_xfer + 1) passed++;
            else $display("FAIL %s.back_to_back: output at cycle %0d expected %0d", e.name, cyc, last_xfer + 1);
          end
        end
        last_xfer = cyc;
      end
      while (prq.size() > 0) begin
        p = prq.pop_front();
        total++;
        if (p.act === p.exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", p.name, p.act, p.exp);
      end
    end
  end

  task automatic probe(input string n, input logic [63:0] a, input logic [63:0] e);
    prq.push_back('{name: n, act: a, exp: e});
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic [3:0] f, input string n,
                       input bit chain, input bit want_out);
    bit acc;
    acc      = 1'b0;
    op_sel   = op;
    operand1 = a;
    operand2 = b;
    in_valid = 1'b1;
    for (int w = 0; w < 50; w++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        break;
      end
    end
    if (!acc) probe({n, ".accept_timeout"}, 64'd0, 64'd1);
    else if (want_out) sbq.push_back('{res: r, flg: f, chain: chain, name: n});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Latency n after acceptance: out_valid low and in_ready low until cycle n.
  task automatic shift_track(input int n, input string nm);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      probe({nm, ".out_valid"}, 64'(out_valid), (k == n) ? 64'd1 : 64'd0);
      if (k < n) probe({nm, ".in_ready_busy"}, 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int          c0;
    logic [31:0] iv;
    logic [3:0]  fl;
    rst_n     = 1'b0;
    ce        = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op_sel    = ADD;
    operand1  = '0;
    operand2  = '0;

    #2;
    fl = flags;
    probe("reset.out_valid", 64'(out_valid), 64'd0);
    probe("reset.result", 64'(result), 64'd0);
    probe("reset.flags", 64'(fl), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single-cycle ops
    issue(ADD, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 4'b1010, "add_carry", 0, 1);
    @(negedge clk);
    probe("add_carry.latency", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
    issue(ADD,  32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 4'b0101, "add_ovf",  0, 1);
    issue(SUB,  32'd3,         32'd5,         32'hFFFF_FFFE, 4'b0110, "sub_brw",  0, 1);
    issue(SLT,  32'hFFFF_FFFF, 32'd1,         32'd1,         4'b0000, "slt",      0, 1);
    issue(SLTU, 32'hFFFF_FFFF, 32'd1,         32'd0,         4'b1000, "sltu",     0, 1);
    issue(XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 4'b0000, "xor",      0, 1);
    issue(OR,   32'h0000_1200, 32'h0000_0034, 32'h0000_1234, 4'b0000, "or",       0, 1);
    issue(AND,  32'hAAAA_AAAA, 32'h5555_5555, 32'h0000_0000, 4'b1000, "and",      0, 1);
    issue(SUB,  32'd5,         32'd5,         32'h0000_0000, 4'b1000, "sub_zero", 0, 1);
    issue(SUB,  32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 4'b0001, "sub_ovf",  0, 1);
    issue(alu_op_t'(4'd12), 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 4'b1000, "unknown", 0, 1);
    issue(LSL,  32'hDEAD_BEEF, 32'h0000_0020, 32'hDEAD_BEEF, 4'b0100, "lsl_amt0", 0, 1);
    @(negedge clk);
    probe("lsl_amt0.no_shift_state", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Multi-cycle shifts
    issue(SRA, 32'h8000_0000, 32'h0000_0023, 32'hF000_0000, 4'b0100, "sra3", 0, 1);
    shift_track(2, "sra3");
    issue(LSR, 32'h8000_0000, 32'd31, 32'h0000_0001, 4'b0000, "lsr31", 0, 1);
    shift_track(5, "lsr31");

    // Ten back-to-back ADDs
    c0 = cyc;
    for (int i = 1; i <= 10; i++) begin
      iv = 32'(i);
      issue(ADD, iv, iv << 4, iv * 32'd17, 4'b0000, "b2b_add", (i > 1), 1);
    end
    probe("b2b.accept_cycles", 64'(cyc - c0), 64'd10);

    // Output stall, then ce=0 with a valid result held
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b0;
    issue(ADD, 32'h11, 32'h22, 32'h33, 4'b0000, "stall_add", 0, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      probe("stall.out_valid", 64'(out_valid), 64'd1);
      probe("stall.result", 64'(result), 64'h33);
      probe("stall.in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    ce        = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      probe("ce_hold.out_valid", 64'(out_valid), 64'd1);
      probe("ce_hold.result", 64'(result), 64'h33);
      probe("ce_hold.in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    ce = 1'b1;

    // ce=0 for 4 cycles mid-shift; remaining latency must be unchanged
    issue(LSL, 32'd1, 32'd31, 32'h8000_0000, 4'b0100, "ce_lsl31", 0, 1);
    ce = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      probe("ce_freeze.out_valid", 64'(out_valid), 64'd0);
      probe("ce_freeze.in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    ce = 1'b1;
    shift_track(5, "ce_lsl31_resume");

    // Reset mid-shift aborts with no result
    issue(LSL, 32'd1, 32'd20, 32'd0, 4'b0000, "rst_lsl20", 0, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    fl = flags;
    probe("rst_mid.out_valid", 64'(out_valid), 64'd0);
    probe("rst_mid.result", 64'(result), 64'd0);
    probe("rst_mid.flags", 64'(fl), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    probe("rst_release.in_ready", 64'(in_ready), 64'd1);
    repeat (8) @(negedge clk);
    probe("rst_release.no_output", 64'(out_valid), 64'd0);

    repeat (3) @(negedge clk);
    probe("scoreboard_drained", 64'(sbq.size()), 64'd0);
    repeat (2) @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter XLEN, default 32, datapath width; SHALL be a power of two, at least 8.
REQ-002 Parameter SHIFT_STEP, default 8, maximum bit positions shifted per cycle; SHALL be a power of two with 1 <= SHIFT_STEP <= XLEN.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 ce  input  1  clock enable; low freezes all state.
REQ-006 in_valid  input  1  operation request valid.
REQ-007 in_ready  output  1  block can accept a request this cycle.
REQ-008 op_sel  input  alu_op_t  operation: ADD, SUB, XOR, OR, AND, LSL, LSR, SRA, SLT, SLTU; the SRA, SLT and SLTU enumerators are added to alu_op_t in instr.sv.
REQ-009 operand1, operand2  input  XLEN each  source operands.
REQ-010 out_valid  output  1  result and flags valid.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 result  output  XLEN  registered result.
REQ-013 flags  output  alu_flags_t  registered zero, sign, carry and overflow; the carry member is added to alu_flags_t.

Function
REQ-014 Input transfer SHALL occur when in_valid, in_ready and ce are all high; output transfer SHALL occur when out_valid, out_ready and ce are all high.
REQ-015 in_ready SHALL equal ce AND state==IDLE AND (NOT out_valid OR out_ready).
REQ-016 FSM states SHALL be IDLE and SHIFT.
- IDLE to SHIFT: a shift op is accepted with a nonzero amount.
- SHIFT to IDLE: the final step completes and the result is loaded.
REQ-017 Single-cycle ops SHALL have out_valid high on the cycle after acceptance, giving throughput 1 per cycle when out_ready is held high.
- Single-cycle ops: ADD, SUB, XOR, OR, AND, SLT, SLTU, unknown ops, and shifts with amount 0.
REQ-018 SLT SHALL return 1 if operand1 < operand2 as signed values, else 0; SLTU SHALL do the same comparison unsigned.
REQ-019 The shift amount SHALL be operand2[$clog2(XLEN)-1:0]; upper operand2 bits SHALL be ignored.
- LSL and LSR fill with zeros.
- SRA fills with operand1[XLEN-1].
REQ-020 For a shift with amount A > 0:
- Each cycle in SHIFT, the working value SHALL shift by min(SHIFT_STEP, remaining) and the remaining count SHALL decrement by the same amount.
- out_valid SHALL rise ceil(A/SHIFT_STEP)+1 cycles after acceptance, provided the output register is free.
REQ-021 If the final shift step completes while out_valid=1 and out_ready=0, the block SHALL remain in SHIFT with the completed value held and load it on the first cycle the output register frees.
REQ-022 Flags SHALL be computed from the value loaded into result and registered with it.
- zero = (result==0).
- sign = result[XLEN-1].
- carry = ADD carry-out, or SUB borrow (operand1 < operand2 unsigned); 0 for all other ops.
- overflow = signed overflow for ADD and SUB; 0 for all other ops.
REQ-023 Unknown op_sel SHALL produce result 0 with flags zero=1, sign=0, carry=0, overflow=0.
REQ-024 While out_valid=1 and no output transfer occurs, result and flags SHALL hold stable.
REQ-025 When an output transfer and a new input transfer occur in the same cycle, the new single-cycle result SHALL appear on the next cycle with no bubble.
REQ-026 While ce=0:
- No transfer SHALL occur and no register SHALL change.
- in_ready SHALL read 0.
- out_valid, result and flags SHALL hold their values.
REQ-027 in_valid high while in_ready=0 SHALL be ignored; the producer SHALL hold the request until it is accepted.

Reset
REQ-028 While rst_n=0, the block SHALL immediately force:
- state = IDLE, out_valid = 0, result = 0, all flags = 0.
- working value and remaining count = 0.
REQ-029 Reset asserted mid-shift SHALL abort the shift with no result ever produced; after release, in_ready SHALL equal ce.

Verification
REQ-030 The bench SHALL cover the following scenarios (XLEN=32, SHIFT_STEP=8):
- ADD 0xFFFFFFFF + 1 -> next cycle result=0, zero=1, carry=1, overflow=0; ADD 0x7FFFFFFF + 1 -> result 0x80000000, sign=1, overflow=1, carry=0.
- SUB 3 - 5 -> result 0xFFFFFFFE, carry=1, sign=1; SLT 0xFFFFFFFF, 1 -> 1; SLTU with the same operands -> 0.
- SRA 0x80000000 by operand2 = 0x23 (amount 3) -> result 0xF0000000, out_valid 2 cycles after accept; LSR 0x80000000 by 31 -> result 1, out_valid 5 cycles after accept, in_ready=0 throughout.
- Ten back-to-back ADDs with out_ready=1 -> ten results on consecutive cycles; out_ready=0 for 3 cycles -> result stable and in_ready=0 during the stall.
- ce=0 for 4 cycles mid-shift -> no state change; on ce=1, the remaining latency resumes unchanged.
- rst_n low during an LSL by 20 -> out_valid=0 and result=0 immediately; no result emitted after release.
